// File: rtl/cpu_result_checker.sv
// Self-checking monitor for the CPU result bus: compares each qualified sample against a
// preloaded table of expected values and reports a synthesizable pass/fail summary.
module cpu_result_checker #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MAX_CYCLES   = 64,
    parameter bit          STOP_ON_FAIL = 1'b0,
    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned MW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [MW-1:0]    mismatch_count,
    output logic [AW-1:0]    first_fail_idx,
    output logic [WIDTH-1:0] first_fail_value
);

    localparam int unsigned CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [MW-1:0]    mismatch_count_q, mismatch_count_d;
    logic [AW-1:0]    first_fail_idx_q, first_fail_idx_d;
    logic [WIDTH-1:0] first_fail_value_q, first_fail_value_d;
    logic             timeout_q, timeout_d;

    // Sized to the full index space so any load_addr is a legal write target.
    logic [WIDTH-1:0] exp_mem [1 << AW];

    always_ff @(posedge clk) begin
        if (load_we && state_q == StIdle) begin
            exp_mem[load_addr] <= load_data;
        end
    end

    logic sample_mis;
    logic sample_last;

    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        cycle_cnt_d        = cycle_cnt_q;
        mismatch_count_d   = mismatch_count_q;
        first_fail_idx_d   = first_fail_idx_q;
        first_fail_value_d = first_fail_value_q;
        timeout_d          = timeout_q;
        sample_mis         = sample_valid && (sample != exp_mem[idx_q]);
        sample_last        = sample_valid && (idx_q == AW'(DEPTH - 1));

        unique case (state_q)
            StIdle, StPass, StFail: begin
                if (start) begin
                    state_d            = StRun;
                    idx_d              = '0;
                    cycle_cnt_d        = '0;
                    mismatch_count_d   = '0;
                    first_fail_idx_d   = '0;
                    first_fail_value_d = '0;
                    timeout_d          = 1'b0;
                end
            end
            StRun: begin
                cycle_cnt_d = cycle_cnt_q + CW'(1);
                if (sample_mis) begin
                    if (mismatch_count_q != MW'(DEPTH)) begin
                        mismatch_count_d = mismatch_count_q + MW'(1);
                    end
                    if (mismatch_count_q == '0) begin
                        first_fail_idx_d   = idx_q;
                        first_fail_value_d = sample;
                    end
                end
                if (sample_valid) begin
                    idx_d = idx_q + AW'(1);
                end
                // Completion wins over an expiring budget in the same cycle.
                if (sample_last) begin
                    state_d = (mismatch_count_d == '0) ? StPass : StFail;
                end else if (sample_mis && STOP_ON_FAIL) begin
                    state_d = StFail;
                end else if (cycle_cnt_q == CW'(MAX_CYCLES - 1)) begin
                    state_d   = StFail;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StIdle;
            idx_q              <= '0;
            cycle_cnt_q        <= '0;
            mismatch_count_q   <= '0;
            first_fail_idx_q   <= '0;
            first_fail_value_q <= '0;
            timeout_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            cycle_cnt_q        <= cycle_cnt_d;
            mismatch_count_q   <= mismatch_count_d;
            first_fail_idx_q   <= first_fail_idx_d;
            first_fail_value_q <= first_fail_value_d;
            timeout_q          <= timeout_d;
        end
    end

    assign busy             = (state_q == StRun);
    assign done             = (state_q == StPass) || (state_q == StFail);
    assign pass             = (state_q == StPass);
    assign timeout          = timeout_q;
    assign mismatch_count   = mismatch_count_q;
    assign first_fail_idx   = first_fail_idx_q;
    assign first_fail_value = first_fail_value_q;

endmodule

// File: tb/tb_cpu_result_checker.sv
// Directed bench: dut_a checks all entries with a long budget, dut_b stops on first
// fail with a 6-cycle budget; both share one stimulus stream.
module tb_cpu_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [1:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        sample_valid;
    logic [31:0] sample;

    logic        a_busy, a_done, a_pass, a_timeout;
    logic [2:0]  a_mc;
    logic [1:0]  a_ffi;
    logic [31:0] a_ffv;
    logic        b_busy, b_done, b_pass, b_timeout;
    logic [2:0]  b_mc;
    logic [1:0]  b_ffi;
    logic [31:0] b_ffv;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_result_checker #(
        .WIDTH(32), .DEPTH(4), .MAX_CYCLES(64), .STOP_ON_FAIL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .sample_valid(sample_valid), .sample(sample),
        .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_timeout),
        .mismatch_count(a_mc), .first_fail_idx(a_ffi), .first_fail_value(a_ffv)
    );

    cpu_result_checker #(
        .WIDTH(32), .DEPTH(4), .MAX_CYCLES(6), .STOP_ON_FAIL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .sample_valid(sample_valid), .sample(sample),
        .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_timeout),
        .mismatch_count(b_mc), .first_fail_idx(b_ffi), .first_fail_value(b_ffv)
    );

    localparam logic [31:0] E0 = 32'd5;
    localparam logic [31:0] E1 = 32'hFFFF_FFFD;
    localparam logic [31:0] E2 = 32'd0;
    localparam logic [31:0] E3 = 32'h7FFF_FFFF;

    typedef struct {
        logic [3:0][31:0] s;
        logic             exp_pass;
        logic [2:0]       exp_mc;
        logic [1:0]       exp_ffi;
        logic [31:0]      exp_ffv;
    } vec_t;

    vec_t vecs [5];
    logic [31:0] exp_tab [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input logic p, input logic [2:0] mc,
                                input logic [1:0] ffi, input logic [31:0] ffv);
        vec_t v;
        v.s        = {s3, s2, s1, s0};
        v.exp_pass = p;
        v.exp_mc   = mc;
        v.exp_ffi  = ffi;
        v.exp_ffv  = ffv;
        return v;
    endfunction

    task automatic start_run;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds four back-to-back valid samples; checks dut_a is not done before the last one.
    task automatic feed4(input logic [3:0][31:0] s);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("a_done_before_last", a_done, 1'b0);
            sample_valid = 1'b1;
            sample       = s[i];
            tick();
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        exp_tab = '{E0, E1, E2, E3};
        vecs[0] = mk(E0, E1, E2, E3, 1'b1, 3'd0, 2'd0, 32'h0);
        vecs[1] = mk(E0, E1, 32'd1, E3, 1'b0, 3'd1, 2'd2, 32'd1);
        vecs[2] = mk(32'd9, E1, E2, 32'd0, 1'b0, 3'd2, 2'd0, 32'd9);
        vecs[3] = mk(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 3'd4, 2'd0, 32'd1);
        vecs[4] = mk(E0, E1, E2, 32'h8000_0000, 1'b0, 3'd1, 2'd3, 32'h8000_0000);

        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; sample_valid = 1'b0; sample = '0;
        #2;
        chk("reset_a_busy", a_busy, 1'b0);
        chk("reset_a_done", a_done, 1'b0);
        chk("reset_a_pass", a_pass, 1'b0);
        chk("reset_a_mc", a_mc, 3'd0);
        chk("reset_b_timeout", b_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load_we = 1'b1; load_addr = 2'(i); load_data = exp_tab[i];
            tick();
        end
        load_we = 1'b0;

        // Table-driven full runs on dut_a, each starting from the previous run's end state.
        for (int v = 0; v < 5; v++) begin
            start_run();
            chk($sformatf("v%0d_a_busy", v), a_busy, 1'b1);
            feed4(vecs[v].s);
            chk($sformatf("v%0d_a_done", v), a_done, 1'b1);
            chk($sformatf("v%0d_a_pass", v), a_pass, vecs[v].exp_pass);
            chk($sformatf("v%0d_a_mc", v), a_mc, vecs[v].exp_mc);
            chk($sformatf("v%0d_a_ffi", v), a_ffi, vecs[v].exp_ffi);
            chk($sformatf("v%0d_a_ffv", v), a_ffv, vecs[v].exp_ffv);
            chk($sformatf("v%0d_a_timeout", v), a_timeout, 1'b0);
        end

        // Stop on fail: dut_b finishes right after the bad sample; writes in RUN are ignored.
        start_run();
        sample_valid = 1'b1; sample = E0;
        tick();
        sample = 32'd99; load_we = 1'b1; load_addr = 2'd0; load_data = 32'hDEAD;
        tick();
        load_we = 1'b0;
        chk("sof_b_done", b_done, 1'b1);
        chk("sof_b_busy", b_busy, 1'b0);
        chk("sof_b_mc", b_mc, 3'd1);
        chk("sof_b_ffi", b_ffi, 2'd1);
        chk("sof_b_ffv", b_ffv, 32'd99);
        chk("sof_a_busy", a_busy, 1'b1);
        sample = E2; tick();
        sample = E3; tick();
        sample_valid = 1'b0;
        chk("sof_b_mc_held", b_mc, 3'd1);
        chk("sof_b_pass", b_pass, 1'b0);
        chk("sof_a_done", a_done, 1'b1);
        chk("sof_a_mc", a_mc, 3'd1);
        chk("sof_a_ffi", a_ffi, 2'd1);

        // Gapped valids: dut_b runs out of its 6-cycle budget after three samples.
        start_run();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) chk("to_b_busy_last_cycle", b_busy, 1'b1);
            sample_valid = (k % 2 == 0);
            sample       = exp_tab[k / 2];
            tick();
        end
        sample_valid = 1'b0;
        chk("to_b_done", b_done, 1'b1);
        chk("to_b_timeout", b_timeout, 1'b1);
        chk("to_b_pass", b_pass, 1'b0);
        chk("to_b_mc", b_mc, 3'd0);
        chk("to_a_busy", a_busy, 1'b1);
        sample_valid = 1'b1; sample = E3;
        tick();
        sample_valid = 1'b0;
        chk("to_a_pass", a_pass, 1'b1);
        chk("to_a_timeout", a_timeout, 1'b0);

        // Back-to-back: mismatching stream from PASS, then restart straight out of FAIL.
        start_run();
        chk("b2b_b_timeout_cleared", b_timeout, 1'b0);
        feed4({32'd4, 32'd3, 32'd2, 32'd1});
        chk("b2b_a_fail", a_done & ~a_pass, 1'b1);
        chk("b2b_a_mc_sat", a_mc, 3'd4);
        start_run();
        chk("b2b_a_mc_cleared", a_mc, 3'd0);
        chk("b2b_a_ffv_cleared", a_ffv, 32'h0);
        chk("b2b_a_busy", a_busy, 1'b1);
        feed4({E3, E2, E1, E0});
        chk("b2b_a_pass", a_pass, 1'b1);

        // Reset between edges mid-run, then restart with a load in the start cycle.
        start_run();
        sample_valid = 1'b1; sample = 32'd7;
        tick();
        sample_valid = 1'b0;
        chk("rst_a_mc_before", a_mc, 3'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_mc", a_mc, 3'd0);
        chk("rst_a_ffv", a_ffv, 32'h0);
        chk("rst_b_done", b_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        load_we = 1'b1; load_addr = 2'd3; load_data = 32'h1234_5678;
        start_run();
        load_we = 1'b0;
        chk("rst2_a_busy", a_busy, 1'b1);
        feed4({32'h1234_5678, E2, E1, E0});
        chk("rst2_a_pass", a_pass, 1'b1);
        chk("rst2_a_mc", a_mc, 3'd0);
        chk("rst2_b_pass", b_pass, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_result_checker.md
Name: cpu_result_checker

Overview:
- Self-checking monitor for the CPU `Result` bus: compares one sample per accepted cycle against a preloaded table of expected values.
- Replaces per-cycle printing of results with a synthesizable pass/fail summary.
- Sits beside the cpu instance in simulation and FPGA bring-up builds, on the same clock and reset.
- Generalises result watching in four ways: parametrised width and depth, sample qualification, timeout, and a stop-on-first-fail mode.

Parameters:
- WIDTH, 32, data width of the result bus and of the expected-value entries.
- DEPTH, 16, number of expected results; AW = max(1, $clog2(DEPTH)).
- MAX_CYCLES, 64, RUN-state cycle budget before timeout (must be at least 1).
- STOP_ON_FAIL, 0, 1 = finish at the first mismatch; 0 = check all DEPTH entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load_we  in  1  write enable into the expected table; honoured only in IDLE.
- load_addr  in  AW  expected-table index.
- load_data  in  WIDTH  expected value.
- start  in  1  begin a check run; honoured only in IDLE.
- sample_valid  in  1  sample is a result to check this cycle.
- sample  in  WIDTH  CPU result value.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS only.
- timeout  out  1  the run ended by cycle budget.
- mismatch_count  out  $clog2(DEPTH+1)  number of failed compares.
- first_fail_idx  out  AW  index of the first mismatch.
- first_fail_value  out  WIDTH  sample value at the first mismatch.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs and counters go to 0.
  - The expected table is not cleared.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - load_we writes exp[load_addr] <= load_data at the clock edge.
  - A start pulse clears idx, cycle_cnt, mismatch_count, first_fail_* and timeout, then moves to RUN.
  - If start and load_we are both high in the same cycle, the write completes first and start is still taken; the written entry is valid for the run.
- RUN:
  - cycle_cnt increments every cycle.
  - Each cycle with sample_valid=1 compares sample against exp[idx]. The compare is combinational from the registered idx, so the sample is checked in its own cycle.
  - On a mismatch:
    - mismatch_count increments.
    - If this is the first mismatch, first_fail_idx <= idx and first_fail_value <= sample.
    - If STOP_ON_FAIL=1, go to FAIL next cycle.
  - idx increments on every accepted sample.
  - When the accepted sample has idx == DEPTH-1, go to PASS if the total mismatch count (including this sample) is 0, else FAIL.
  - If cycle_cnt reaches MAX_CYCLES-1 with no completion that cycle, go to FAIL and set timeout=1.
  - Completion in the same cycle as the budget expiring counts as completion; timeout stays 0.
  - sample_valid=0 cycles consume budget but do not advance idx.
  - load_we and start are ignored.
- PASS / FAIL:
  - Outputs hold.
  - start returns to IDLE semantics: the same cycle clears results and enters RUN, allowing back-to-back runs.
  - load_we is ignored.
- Output flags: busy, done and pass are decoded from the registered state (no glitch paths).
- Widths: mismatch_count saturates at DEPTH and can never wrap.
- Reset mid-RUN aborts immediately; a new run requires start.

Test Plan:
- All-match run: WIDTH=32, DEPTH=4.
  - Stimulus: load 5, -3, 0, 0x7FFFFFFF; start; four valid samples with the same values.
  - Response: done=1, pass=1, mismatch_count=0, timeout=0, exactly 5 cycles after start.
- Single mismatch, STOP_ON_FAIL=0.
  - Stimulus: sample[2]=1 instead of 0.
  - Response: FAIL after 4 samples, mismatch_count=1, first_fail_idx=2, first_fail_value=1.
- Stop on fail, STOP_ON_FAIL=1.
  - Stimulus: sample[1] mismatches.
  - Response: done=1 the cycle after sample 1; later samples ignored; mismatch_count=1.
- Gapped valids plus timeout, MAX_CYCLES=6.
  - Stimulus: valid only every other cycle.
  - Response: FAIL with timeout=1 after 6 RUN cycles, idx stopped at 3, pass=0.
- Reset mid-run, then restart.
  - Stimulus: assert rst between clock edges during RUN; then start with the correct stream.
  - Response: all outputs 0 immediately; the table survives and the next run passes.
- Back-to-back runs.
  - Stimulus: start pulsed in PASS with a mismatching stream.
  - Response: counters cleared the same cycle; second run reports FAIL with mismatch_count=DEPTH (saturation check).
